// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Also hosts the NOP control word that MuxControlSignal injects when S=1.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam int REG_ZERO = 0;

  // Control word width of the ID/EX control bundle; a bubble is all zeros.
  localparam int CTRL_W = 16;
  localparam logic [CTRL_W-1:0] NOP_CTRL = '0;

  function automatic logic src_hit(input logic use_src, input logic [31:0] src,
                                   input logic [31:0] dst);
    return use_src && (src == dst);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with async active-low reset and synchronous clear.
// Holds at all ones once reached; clear has priority over enable.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: PC/IF-ID load enables, NOP injection,
// annul flush and memory-wait freeze. Optional stall counter: HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W             = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MAX_WAIT          = 15,
  parameter int CNT_W             = 16
) (
  input  logic             Clk,
  input  logic             R,
  input  logic [REG_W-1:0] ID_rs1,
  input  logic [REG_W-1:0] ID_rs2,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic             ID_B_instr,
  input  logic             ID_29_a,
  input  logic             branch_taken,
  input  logic [REG_W-1:0] EX_rd,
  input  logic             EX_load_instr,
  input  logic             EX_RF_enable,
  input  logic             MEM_DataMem_enable,
  input  logic             DM_ready,
  output logic             LE_PC,
  output logic             LE_IF_ID,
  output logic             S,
  output logic             IF_ID_flush,
  output logic             Pipe_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [1:0]       dbg_state
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int BUB_W  = $clog2(LOAD_STALL_CYCLES + 1);
  localparam bit MULTI_BUBBLE = (LOAD_STALL_CYCLES > 1);
  localparam logic [BUB_W-1:0]  BUB_INIT  = BUB_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t            state_q, state_d;
  logic [BUB_W-1:0]  bub_q, bub_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              memwait, loaduse, annul;
  logic              rs1_hit, rs2_hit;

  // Memory handshake: an access in MEM (enable) completes in the cycle DM_ready
  // is high; every enabled cycle without DM_ready is a wait cycle. Hazard terms
  // are gated by R so reset forces plain RUN outputs regardless of inputs.
  assign rs1_hit = src_hit(ID_use_rs1, 32'(ID_rs1), 32'(EX_rd));
  assign rs2_hit = src_hit(ID_use_rs2, 32'(ID_rs2), 32'(EX_rd));
  assign memwait = R && MEM_DataMem_enable && !DM_ready;
  assign loaduse = R && EX_load_instr && EX_RF_enable &&
                   (EX_rd != REG_W'(REG_ZERO)) && (rs1_hit || rs2_hit);
  assign annul   = R && ID_B_instr && ID_29_a && !branch_taken;

  assign dbg_state = state_q;

  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      state_q <= RUN;
      bub_q   <= '0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bub_d   = bub_q;
    if (memwait) begin
      state_d = MEM_WAIT;
      bub_d   = '0;
    end else begin
      case (state_q)
        LD_STALL: begin
          if (bub_q <= BUB_W'(1)) begin
            state_d = RUN;
            bub_d   = '0;
          end else begin
            bub_d = bub_q - BUB_W'(1);
          end
        end
        default: begin
          // RUN, and MEM_WAIT on its release cycle, re-evaluate as RUN.
          state_d = RUN;
          if (loaduse && MULTI_BUBBLE) begin
            state_d = LD_STALL;
            bub_d   = BUB_INIT;
          end
        end
      endcase
    end
  end

  always_comb begin
    LE_PC       = 1'b1;
    LE_IF_ID    = 1'b1;
    S           = 1'b0;
    IF_ID_flush = 1'b0;
    Pipe_hold   = 1'b0;
    if (memwait) begin
      LE_PC     = 1'b0;
      LE_IF_ID  = 1'b0;
      Pipe_hold = 1'b1;
    end else if ((state_q == LD_STALL) || loaduse) begin
      LE_PC    = 1'b0;
      LE_IF_ID = 1'b0;
      S        = 1'b1;
    end else if (annul) begin
      IF_ID_flush = 1'b1;
    end
  end

  // wait_cnt counts consecutive wait cycles; the timeout latches on the wait
  // cycle that brings the count to MAX_WAIT.
  sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .clk   (Clk),
    .rst_n (R),
    .clear (!memwait),
    .en    (memwait),
    .count (wait_cnt)
  );

  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      mem_timeout <= 1'b0;
    end else if (memwait && (wait_cnt >= WAIT_LAST)) begin
      mem_timeout <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (Clk),
    .rst_n (R),
    .clear (1'b0),
    .en    (!LE_PC),
    .count (stall_cycles)
  );
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Sequencing controller for the five-stage SPARC-subset pipeline (PC/nPC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates the load enables for PC, nPC and IF/ID.
- Drives S of MuxControlSignal (S=1 injects an all-zero NOP control word into ID/EX).
- Flushes IF/ID for annulled delay slots and freezes the whole pipeline while data memory is not ready.
- Sits beside ControlUnit; consumes decoded ID/EX/MEM fields.

Parameters:
REG_W, 5, register specifier width
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (>=1)
MAX_WAIT, 15, data-memory wait cycles before timeout flag
CNT_W, 16, stall performance counter width

Ports:
Clk  in  1  pipeline clock, rising edge
R  in  1  reset, asynchronous, active-low
ID_rs1  in  REG_W  source 1 of instruction in ID
ID_rs2  in  REG_W  source 2 of instruction in ID
ID_use_rs1  in  1  ID instruction reads rs1
ID_use_rs2  in  1  ID instruction reads rs2
ID_B_instr  in  1  ID holds a conditional branch
ID_29_a  in  1  annul bit of the branch in ID
branch_taken  in  1  condition outcome for the ID branch
EX_rd  in  REG_W  destination of instruction in EX
EX_load_instr  in  1  EX holds a load
EX_RF_enable  in  1  EX instruction writes RF
MEM_DataMem_enable  in  1  MEM stage accesses data memory
DM_ready  in  1  data memory completes access this cycle
LE_PC  out  1  load enable for PC and nPC
LE_IF_ID  out  1  load enable for IF/ID
S  out  1  MuxControlSignal select, 1 = NOP
IF_ID_flush  out  1  IF/ID loads NOP at next edge
Pipe_hold  out  1  ID/EX, EX/MEM, MEM/WB hold current value
mem_timeout  out  1  sticky: MEM_WAIT exceeded MAX_WAIT
stall_cycles  out  CNT_W  saturating count of cycles with LE_PC=0

Behaviour:
Hazard terms (combinational):
- memwait = MEM_DataMem_enable & ~DM_ready.
- loaduse = EX_load_instr & EX_RF_enable & EX_rd!=0 & ((ID_use_rs1 & ID_rs1==EX_rd) | (ID_use_rs2 & ID_rs2==EX_rd)). Register r0 never hazards.
- annul = ID_B_instr & ID_29_a & ~branch_taken.

FSM states RUN, LD_STALL, MEM_WAIT. Outputs decode from state plus hazard terms in the same cycle (Mealy). Priority: memwait > loaduse > annul.

RUN:
- memwait: LE_PC=0, LE_IF_ID=0, Pipe_hold=1, S=0; next MEM_WAIT, wait_cnt<=1.
- else loaduse: LE_PC=0, LE_IF_ID=0, S=1. If LOAD_STALL_CYCLES>1, next LD_STALL with bub_cnt<=LOAD_STALL_CYCLES-1; else stay RUN.
- else annul: IF_ID_flush=1, all LEs 1.
- else: LE_PC=LE_IF_ID=1, S=0, flush=0, hold=0.

LD_STALL:
- Outputs as the loaduse case, with S=1.
- bub_cnt decrements each cycle; at 1, next RUN.
- memwait arriving here preempts: next MEM_WAIT, hold asserted that cycle.

MEM_WAIT:
- Outputs LE_PC=LE_IF_ID=0, Pipe_hold=1, S=0.
- DM_ready=1: release that cycle (RUN outputs recomputed combinationally); next RUN.
- wait_cnt increments, saturating. When wait_cnt==MAX_WAIT, set mem_timeout; stay MEM_WAIT.
- mem_timeout clears only on reset.

Outputs and counters:
- annul is ignored while any stall is asserted; it is re-evaluated when the branch re-presents.
- stall_cycles increments every edge at which LE_PC=0, saturating at all ones.

Reset (R=0, any time, including mid-stall):
- Async to RUN; bub_cnt=wait_cnt=0.
- Outputs LE_PC=1, LE_IF_ID=1, S=0, IF_ID_flush=0, Pipe_hold=0, mem_timeout=0, stall_cycles=0.
- Hazard inputs are ignored while R=0.

Optional Feature:
HAZARD_PERF_CNT_EN:
- Defined: stall_cycles counter implemented as specified.
- Undefined: no counter flops; stall_cycles tied to 0. All other behaviour is identical.

Decomposition:
Package pipeline_ctrl_pkg holds:
- FSM state typedef (RUN, LD_STALL, MEM_WAIT).
- Constant REG_ZERO=0.
- NOP control-word constant shared with MuxControlSignal.

One sub-module, sat_counter (parameter width, enable, async active-low clear), instanced for wait_cnt and stall_cycles.

Test Plan:
1. Reset: R=0 at t=0, released t=3, no hazards → LE_PC=1, S=0, stall_cycles=0, PC advances by 4 per cycle.
2. Load-use: EX load rd=5, ID rs1=5 use_rs1=1 → one cycle LE_PC=0, S=1, next cycle LE_PC=1, stall_cycles=1. Repeat with EX_rd=0 → no stall.
3. LOAD_STALL_CYCLES=3, same hazard → S=1 for exactly 3 cycles, stall_cycles=3.
4. Annul: ID_B_instr=1, a=1, branch_taken=0 → IF_ID_flush=1 for one cycle. With branch_taken=1 → flush=0.
5. Memory wait: DataMem_enable=1, DM_ready=0 for 4 cycles then 1 → Pipe_hold=1 for 4 cycles, released on the ready cycle, mem_timeout=0. Held 15 cycles → mem_timeout=1 until reset.
6. Simultaneous/abort: memwait plus loaduse the same cycle → hold wins (S=0); R=0 mid-MEM_WAIT → immediate RUN outputs, counters cleared.
